// File: rtl/proc_hier_pkg.sv
// Shared types, default widths and the saturating-increment helper for proc_hier.
package proc_hier_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_REG_SEL_W = 3;
  localparam int unsigned DEF_CNT_W     = 32;

  // Sequencing states of the core wrapper.
  typedef enum logic [1:0] {
    RESET  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } procState_t;

  // Increment value by one unless it already holds the all-ones value of `width` bits.
  function automatic logic [63:0] satInc(input logic [63:0] value, input int unsigned width);
    logic [63:0] maxVal;
    maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= maxVal) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/proc_hier_sat_counter.sv
// Saturating statistics counter with increment enable, freeze and synchronous clear.
module proc_hier_sat_counter
  import proc_hier_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  // Count enabled events; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !freeze) begin
      count <= CNT_W'(satInc(64'(count), CNT_W));
    end
  end

endmodule

// File: rtl/proc_hier.sv
// Processor hierarchy top: run/halt sequencing, cycle and retire counters,
// per-cycle commit trace and sticky error flag.
// Optional: define PROC_HIER_CACHE_STATS_EN to enable the cache request/hit
// counters and the hit-without-request error check.
module proc_hier
  import proc_hier_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned REG_SEL_W = DEF_REG_SEL_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    pc,
  input  logic [DATA_W-1:0]    inst,
  input  logic                 reg_write,
  input  logic [REG_SEL_W-1:0] write_reg,
  input  logic [DATA_W-1:0]    write_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [DATA_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data_in,
  input  logic [DATA_W-1:0]    mem_data_out,
  input  logic                 halt,
  input  logic                 icache_req,
  input  logic                 icache_hit,
  input  logic                 dcache_req,
  input  logic                 dcache_hit,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     inst_count,
  output logic [CNT_W-1:0]     icache_req_cnt,
  output logic [CNT_W-1:0]     icache_hit_cnt,
  output logic [CNT_W-1:0]     dcache_req_cnt,
  output logic [CNT_W-1:0]     dcache_hit_cnt,
  output logic                 trace_valid,
  output logic [DATA_W-1:0]    trace_pc,
  output logic [DATA_W-1:0]    trace_inst,
  output logic                 trace_rw,
  output logic                 trace_mr,
  output logic                 trace_mw,
  output logic [REG_SEL_W-1:0] trace_reg,
  output logic [DATA_W-1:0]    trace_wdata,
  output logic [DATA_W-1:0]    trace_addr,
  output logic [DATA_W-1:0]    trace_mdin,
  output logic [DATA_W-1:0]    trace_mdout,
  output logic                 halted,
  output logic                 err
);

  procState_t stateQ, stateD;
  logic       runEdge;
  logic       errSet;

  // An edge does work when reset is released and the core has not halted.
  assign runEdge = !rst && (stateQ != HALTED);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= RESET;
    else     stateQ <= stateD;
  end

  // Next-state: leave reset on the first free edge, halt is terminal until rst.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      RESET:   stateD = halt ? HALTED : RUN;
      RUN:     if (halt) stateD = HALTED;
      HALTED:  stateD = HALTED;
      default: stateD = RESET;
    endcase
  end

  proc_hier_sat_counter #(.CNT_W(CNT_W)) uCycleCnt (
    .clk(clk), .clear(rst), .inc(1'b1), .freeze(!runEdge), .count(cycle_count)
  );

  proc_hier_sat_counter #(.CNT_W(CNT_W)) uInstCnt (
    .clk(clk), .clear(rst), .inc(halt || reg_write || mem_write), .freeze(!runEdge),
    .count(inst_count)
  );

`ifdef PROC_HIER_CACHE_STATS_EN
  proc_hier_sat_counter #(.CNT_W(CNT_W)) uIcReqCnt (
    .clk(clk), .clear(rst), .inc(icache_req), .freeze(!runEdge), .count(icache_req_cnt)
  );

  proc_hier_sat_counter #(.CNT_W(CNT_W)) uIcHitCnt (
    .clk(clk), .clear(rst), .inc(icache_hit && icache_req), .freeze(!runEdge),
    .count(icache_hit_cnt)
  );

  proc_hier_sat_counter #(.CNT_W(CNT_W)) uDcReqCnt (
    .clk(clk), .clear(rst), .inc(dcache_req), .freeze(!runEdge), .count(dcache_req_cnt)
  );

  proc_hier_sat_counter #(.CNT_W(CNT_W)) uDcHitCnt (
    .clk(clk), .clear(rst), .inc(dcache_hit && dcache_req), .freeze(!runEdge),
    .count(dcache_hit_cnt)
  );
`else
  logic unusedCacheIn;
  assign unusedCacheIn  = ^{icache_req, icache_hit, dcache_req, dcache_hit};
  assign icache_req_cnt = '0;
  assign icache_hit_cnt = '0;
  assign dcache_req_cnt = '0;
  assign dcache_hit_cnt = '0;
`endif

  // Protocol violations seen on this cycle's strobes.
  always_comb begin
    errSet = mem_read && mem_write;
`ifdef PROC_HIER_CACHE_STATS_EN
    errSet = errSet || (icache_hit && !icache_req) || (dcache_hit && !dcache_req);
`endif
  end

  // Sticky halted and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
      err    <= 1'b0;
    end else if (runEdge) begin
      if (halt)   halted <= 1'b1;
      if (errSet) err    <= 1'b1;
    end
  end

  // Commit trace: capture every working edge, hold fields otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_inst  <= '0;
      trace_rw    <= 1'b0;
      trace_mr    <= 1'b0;
      trace_mw    <= 1'b0;
      trace_reg   <= '0;
      trace_wdata <= '0;
      trace_addr  <= '0;
      trace_mdin  <= '0;
      trace_mdout <= '0;
    end else if (runEdge) begin
      trace_valid <= 1'b1;
      trace_pc    <= pc;
      trace_inst  <= inst;
      trace_rw    <= reg_write;
      trace_mr    <= mem_read;
      trace_mw    <= mem_write;
      trace_reg   <= write_reg;
      trace_wdata <= write_data;
      trace_addr  <= mem_addr;
      trace_mdin  <= mem_data_in;
      trace_mdout <= mem_data_out;
    end else begin
      trace_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_hier.sv
// Directed self-checking bench for proc_hier (default widths plus a 4-bit counter build).
module tb_proc_hier;

  logic        clk = 1'b0;
  logic        rst, rstS;
  logic [15:0] pc, inst, writeData, memAddr, memDataIn, memDataOut;
  logic        regWrite, regWriteS, memRead, memWrite, halt;
  logic [2:0]  writeReg;
  logic        icReq, icHit, dcReq, dcHit;

  logic [31:0] cycleCnt, instCnt, icReqCnt, icHitCnt, dcReqCnt, dcHitCnt;
  logic        trValid, trRw, trMr, trMw, halted, err;
  logic [15:0] trPc, trInst, trWdata, trAddr, trMdin, trMdout;
  logic [2:0]  trReg;

  logic [3:0]  cycleS, instS;
  logic [3:0]  unusedS0, unusedS1, unusedS2, unusedS3;
  logic        unusedS4, unusedS5, unusedS6, unusedS7, unusedS8, unusedS9;
  logic [15:0] unusedS10, unusedS11, unusedS12, unusedS13, unusedS14, unusedS15;
  logic [2:0]  unusedS16;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  proc_hier dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .reg_write(regWrite), .write_reg(writeReg),
    .write_data(writeData), .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
    .mem_data_in(memDataIn), .mem_data_out(memDataOut), .halt(halt),
    .icache_req(icReq), .icache_hit(icHit), .dcache_req(dcReq), .dcache_hit(dcHit),
    .cycle_count(cycleCnt), .inst_count(instCnt),
    .icache_req_cnt(icReqCnt), .icache_hit_cnt(icHitCnt),
    .dcache_req_cnt(dcReqCnt), .dcache_hit_cnt(dcHitCnt),
    .trace_valid(trValid), .trace_pc(trPc), .trace_inst(trInst), .trace_rw(trRw),
    .trace_mr(trMr), .trace_mw(trMw), .trace_reg(trReg), .trace_wdata(trWdata),
    .trace_addr(trAddr), .trace_mdin(trMdin), .trace_mdout(trMdout),
    .halted(halted), .err(err)
  );

  proc_hier #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rstS), .pc(pc), .inst(inst), .reg_write(regWriteS), .write_reg(writeReg),
    .write_data(writeData), .mem_read(1'b0), .mem_write(1'b0), .mem_addr(memAddr),
    .mem_data_in(memDataIn), .mem_data_out(memDataOut), .halt(1'b0),
    .icache_req(1'b0), .icache_hit(1'b0), .dcache_req(1'b0), .dcache_hit(1'b0),
    .cycle_count(cycleS), .inst_count(instS),
    .icache_req_cnt(unusedS0), .icache_hit_cnt(unusedS1),
    .dcache_req_cnt(unusedS2), .dcache_hit_cnt(unusedS3),
    .trace_valid(unusedS4), .trace_pc(unusedS10), .trace_inst(unusedS11), .trace_rw(unusedS5),
    .trace_mr(unusedS6), .trace_mw(unusedS7), .trace_reg(unusedS16), .trace_wdata(unusedS12),
    .trace_addr(unusedS13), .trace_mdin(unusedS14), .trace_mdout(unusedS15),
    .halted(unusedS8), .err(unusedS9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock, then settle past the edge before sampling.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleInputs();
    pc = 16'h0; inst = 16'h0; regWrite = 1'b0; writeReg = 3'd0; writeData = 16'h0;
    memRead = 1'b0; memWrite = 1'b0; memAddr = 16'h0; memDataIn = 16'h0; memDataOut = 16'h0;
    halt = 1'b0; icReq = 1'b0; icHit = 1'b0; dcReq = 1'b0; dcHit = 1'b0;
  endtask

  logic [31:0] expErrCache, expIcReq, expIcHit;

  initial begin
`ifdef PROC_HIER_CACHE_STATS_EN
    expErrCache = 32'd1; expIcReq = 32'd8; expIcHit = 32'd6;
`else
    expErrCache = 32'd0; expIcReq = 32'd0; expIcHit = 32'd0;
`endif
    idleInputs();
    rst = 1'b1; rstS = 1'b1; regWriteS = 1'b0;
    pc = 16'h0100; regWrite = 1'b1; memRead = 1'b1; memWrite = 1'b1; halt = 1'b1;

    // Reset holds everything at zero regardless of strobes.
    step(3);
    chk("rst_cycle", cycleCnt, 32'd0);
    chk("rst_inst", instCnt, 32'd0);
    chk("rst_tvalid", 32'(trValid), 32'd0);
    chk("rst_tpc", 32'(trPc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Release: first edge already counts and traces.
    idleInputs();
    rst = 1'b0; pc = 16'h0100; inst = 16'hABCD;
    step(1);
    chk("rel_tvalid", 32'(trValid), 32'd1);
    chk("rel_cycle1", cycleCnt, 32'd1);
    chk("rel_tpc", 32'(trPc), 32'h0100);
    chk("rel_tinst", 32'(trInst), 32'hABCD);
    pc = 16'h0102;
    step(4);
    chk("idle_cycle5", cycleCnt, 32'd5);
    chk("idle_inst0", instCnt, 32'd0);

    // Retire mix: 4 register writes, then 2 stores.
    regWrite = 1'b1; writeReg = 3'd3; writeData = 16'h1234;
    step(1);
    chk("rw_treg", 32'(trReg), 32'd3);
    chk("rw_twdata", 32'(trWdata), 32'h1234);
    chk("rw_trw", 32'(trRw), 32'd1);
    step(3);
    chk("rw_inst4", instCnt, 32'd4);
    regWrite = 1'b0; memWrite = 1'b1; memAddr = 16'h0040; memDataIn = 16'h5A5A;
    step(2);
    chk("mw_inst6", instCnt, 32'd6);
    chk("mw_tmw", 32'(trMw), 32'd1);
    chk("mw_taddr", 32'(trAddr), 32'h0040);
    chk("mw_tmdin", 32'(trMdin), 32'h5A5A);
    chk("mw_trw", 32'(trRw), 32'd0);
    chk("mw_cycle11", cycleCnt, 32'd11);

    // Cache statistics: 8 icache requests, 6 of them hits.
    memWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      icReq = 1'b1; icHit = (i < 6);
      step(1);
    end
    icReq = 1'b0; icHit = 1'b0;
    chk("ic_req_cnt", icReqCnt, expIcReq);
    chk("ic_hit_cnt", icHitCnt, expIcHit);
    chk("ic_err_clean", 32'(err), 32'd0);
    dcHit = 1'b1;
    step(1);
    dcHit = 1'b0;
    chk("dc_hit_cnt", dcHitCnt, 32'd0);
    chk("dc_req_cnt", dcReqCnt, 32'd0);
    chk("dc_orphan_err", 32'(err), expErrCache);
    chk("cache_cycle20", cycleCnt, 32'd20);

    // Halt together with a register write: one retire, counters then freeze.
    halt = 1'b1; regWrite = 1'b1; pc = 16'h0200;
    step(1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_cycle21", cycleCnt, 32'd21);
    chk("halt_inst7", instCnt, 32'd7);
    chk("halt_tvalid", 32'(trValid), 32'd1);
    halt = 1'b0; pc = 16'h0300; memRead = 1'b1; memWrite = 1'b1;
    step(3);
    chk("hlt_cycle_frozen", cycleCnt, 32'd21);
    chk("hlt_inst_frozen", instCnt, 32'd7);
    chk("hlt_tvalid0", 32'(trValid), 32'd0);
    chk("hlt_tpc_hold", 32'(trPc), 32'h0200);
    chk("hlt_err_ignored", 32'(err), expErrCache);
    chk("hlt_still", 32'(halted), 32'd1);

    // Reset out of HALTED, then the read+write protocol error.
    idleInputs();
    rst = 1'b1;
    step(1);
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    rst = 1'b0;
    step(2);
    chk("rst2_cycle2", cycleCnt, 32'd2);
    memRead = 1'b1; memWrite = 1'b1;
    step(1);
    chk("rdwr_err", 32'(err), 32'd1);
    chk("rdwr_inst1", instCnt, 32'd1);
    chk("rdwr_tmr", 32'(trMr), 32'd1);
    chk("rdwr_cycle3", cycleCnt, 32'd3);

    // Reset with a simultaneous halt: halt is ignored.
    memRead = 1'b0; memWrite = 1'b0; rst = 1'b1; halt = 1'b1;
    step(1);
    chk("rsth_cycle", cycleCnt, 32'd0);
    chk("rsth_inst", instCnt, 32'd0);
    chk("rsth_halted", 32'(halted), 32'd0);
    chk("rsth_err", 32'(err), 32'd0);
    chk("rsth_tvalid", 32'(trValid), 32'd0);
    chk("rsth_tmr", 32'(trMr), 32'd0);
    rst = 1'b0; halt = 1'b0;
    step(1);
    chk("rsth_run_cycle1", cycleCnt, 32'd1);
    chk("rsth_run_halted0", 32'(halted), 32'd0);

    // Saturation on the 4-bit build: 20 retires stop at 15.
    idleInputs();
    rstS = 1'b0; regWriteS = 1'b1;
    step(14);
    chk("sat_inst14", 32'(instS), 32'd14);
    step(6);
    chk("sat_inst15", 32'(instS), 32'd15);
    chk("sat_cycle15", 32'(cycleS), 32'd15);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
